midi_rx_note: RTL

- Receives a serial MIDI stream (UART 8N1, 31250 baud) and decodes Note On and Note Off messages into a monophonic note number.
- Drives the `note_select` input of the tone generator in the same clock domain: 0 means silence, non-zero is the MIDI note number of the held note.
- Sits between the board's MIDI-in opto pin and the buzzer tone path.

---
 rtl/midi_rx_note.sv | 348 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/midi_rx_note.sv
// ---------------------------------------------------------------------------
// midi_rx_note
//
// Receives a MIDI serial stream (UART 8N1) and turns Note On / Note Off
// messages into a monophonic note number for the tone generator.
//
// Parameters
//   CLK_FREQ : aclk frequency in Hz
//   BAUD     : serial bit rate; DIV = CLK_FREQ/BAUD clocks per bit (>= 4)
//   CHANNEL  : MIDI channel accepted when omni mode is compiled out
//
// Ports
//   aclk          : system clock
//   areset        : asynchronous active-high reset
//   i_rx          : raw MIDI serial line, idle high, asynchronous to aclk
//   o_note_select : held note number (1..127), 0 when nothing is held
//   o_gate        : high while a note is held
//   o_velocity    : velocity of the last accepted Note On
//   o_note_strobe : one-cycle pulse whenever o_note_select changes
//   o_frame_err   : one-cycle pulse when a stop bit samples low
//
// Build option
//   MIDI_RX_OMNI_EN : when defined, all 16 channels are accepted and
//                     CHANNEL is ignored.
// ---------------------------------------------------------------------------
module midi_rx_note #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 31250,
  parameter logic [3:0] CHANNEL  = 4'd0
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       i_rx,
  output logic [7:0] o_note_select,
  output logic       o_gate,
  output logic [6:0] o_velocity,
  output logic       o_note_strobe,
  output logic       o_frame_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);

  localparam logic [CW-1:0] DIV_C  = CW'(DIV);
  localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = '0;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {S_STATUS, S_NOTE, S_VEL} parse_state_t;

  // Synchroniser
  logic rx_meta_q;
  logic rx_sync_q;

  // UART receiver
  uart_state_t   uart_state_q, uart_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          cnt_expired;

  // Parser
  parse_state_t  parse_state_q, parse_state_d;
  logic [3:0]    run_type_q, run_type_d;
  logic          run_valid_q, run_valid_d;
  logic [6:0]    note_tmp_q, note_tmp_d;
  logic [7:0]    note_q, note_d;
  logic          gate_q, gate_d;
  logic [6:0]    vel_q, vel_d;
  logic          strobe_q, strobe_d;

  // Byte decode
  logic [7:0]    rx_byte;
  logic          is_system;
  logic          is_status;
  logic          is_data;
  logic          chan_ok;
  logic          status_ok;

  // ------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous serial line. Both flops
  // reset to the idle (high) level so reset never looks like a start bit.
  // ------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // The bit counter expires on the cycle it holds 1; the sample is taken
  // on that cycle and the counter is reloaded for the next bit.
  assign cnt_expired = (cnt_q <= ONE_C);

  // ------------------------------------------------------------------
  // UART state register and datapath flops.
  // ------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      uart_state_q <= U_IDLE;
      cnt_q        <= ZERO_C;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      armed_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      uart_state_q <= uart_state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ------------------------------------------------------------------
  // UART next-state logic. A start is only taken once the receiver is
  // armed, so a line that is low when reset is released (we were
  // interrupted mid-byte) cannot be mistaken for a start bit.
  // ------------------------------------------------------------------
  always_comb begin
    uart_state_d = uart_state_q;
    case (uart_state_q)
      U_IDLE: begin
        if (armed_q && !rx_sync_q) begin
          uart_state_d = U_START;
        end
      end
      U_START: begin
        if (cnt_expired) begin
          uart_state_d = rx_sync_q ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (cnt_expired && (bit_cnt_q == 3'd7)) begin
          uart_state_d = U_STOP;
        end
      end
      U_STOP: begin
        if (cnt_expired) begin
          uart_state_d = U_IDLE;
        end
      end
      default: uart_state_d = U_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // UART datapath / outputs. While not yet armed, the idle state reuses
  // the bit counter to require one full bit time of continuous idle
  // before the first start bit after reset is accepted.
  // ------------------------------------------------------------------
  always_comb begin
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (uart_state_q)
      U_IDLE: begin
        if (!armed_q) begin
          if (rx_sync_q) begin
            if (cnt_q >= (DIV_C - ONE_C)) begin
              armed_d = 1'b1;
              cnt_d   = ZERO_C;
            end else begin
              cnt_d = cnt_q + ONE_C;
            end
          end else begin
            cnt_d = ZERO_C;
          end
        end else if (!rx_sync_q) begin
          cnt_d = HALF_C;
        end
      end
      U_START: begin
        if (cnt_expired) begin
          cnt_d     = DIV_C;
          bit_cnt_d = 3'd0;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      U_DATA: begin
        if (cnt_expired) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          cnt_d     = DIV_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      U_STOP: begin
        if (cnt_expired) begin
          cnt_d = ZERO_C;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      default: begin
        cnt_d = ZERO_C;
      end
    endcase
  end

  // The shift register is stable for many cycles after the stop bit, so
  // the parser reads the received byte straight from it.
  assign rx_byte = shift_q;

  // ------------------------------------------------------------------
  // Byte classification. Real-time bytes (F8-FF) match none of these
  // and therefore leave the parser untouched.
  // ------------------------------------------------------------------
  always_comb begin
    is_system = byte_valid_q && (rx_byte[7:3] == 5'b11110);
    is_status = byte_valid_q && rx_byte[7] && (rx_byte[7:4] != 4'hF);
    is_data   = byte_valid_q && !rx_byte[7];
`ifdef MIDI_RX_OMNI_EN
    chan_ok   = 1'b1;
`else
    chan_ok   = (rx_byte[3:0] == CHANNEL);
`endif
    status_ok = ((rx_byte[7:4] == 4'h8) || (rx_byte[7:4] == 4'h9)) && chan_ok;
  end

  // ------------------------------------------------------------------
  // Parser state register and stored message / output registers.
  // ------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      parse_state_q <= S_STATUS;
      run_type_q    <= 4'd0;
      run_valid_q   <= 1'b0;
      note_tmp_q    <= 7'd0;
      note_q        <= 8'd0;
      gate_q        <= 1'b0;
      vel_q         <= 7'd0;
      strobe_q      <= 1'b0;
    end else begin
      parse_state_q <= parse_state_d;
      run_type_q    <= run_type_d;
      run_valid_q   <= run_valid_d;
      note_tmp_q    <= note_tmp_d;
      note_q        <= note_d;
      gate_q        <= gate_d;
      vel_q         <= vel_d;
      strobe_q      <= strobe_d;
    end
  end

  // ------------------------------------------------------------------
  // Parser next-state logic. Any status byte restarts message assembly,
  // which is what aborts a partial message.
  // ------------------------------------------------------------------
  always_comb begin
    parse_state_d = parse_state_q;
    if (is_system) begin
      parse_state_d = S_STATUS;
    end else if (is_status) begin
      parse_state_d = status_ok ? S_NOTE : S_STATUS;
    end else if (is_data) begin
      case (parse_state_q)
        S_STATUS: begin
          if (run_valid_q) begin
            parse_state_d = S_VEL;
          end
        end
        S_NOTE:  parse_state_d = S_VEL;
        S_VEL:   parse_state_d = S_STATUS;
        default: parse_state_d = S_STATUS;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Parser outputs. A completed Note On with non-zero velocity always
  // takes over (last-note priority); a release only acts when it names
  // the note that is currently held. The strobe compares the next note
  // value with the current one so it lines up with the register update.
  // ------------------------------------------------------------------
  always_comb begin
    run_type_d  = run_type_q;
    run_valid_d = run_valid_q;
    note_tmp_d  = note_tmp_q;
    note_d      = note_q;
    gate_d      = gate_q;
    vel_d       = vel_q;
    if (is_system) begin
      run_type_d  = 4'd0;
      run_valid_d = 1'b0;
    end else if (is_status) begin
      if (status_ok) begin
        run_type_d  = rx_byte[7:4];
        run_valid_d = 1'b1;
      end else begin
        run_type_d  = 4'd0;
        run_valid_d = 1'b0;
      end
    end else if (is_data) begin
      case (parse_state_q)
        S_STATUS: begin
          if (run_valid_q) begin
            note_tmp_d = rx_byte[6:0];
          end
        end
        S_NOTE: begin
          note_tmp_d = rx_byte[6:0];
        end
        S_VEL: begin
          if ((run_type_q == 4'h9) && (rx_byte[6:0] != 7'd0)) begin
            note_d = {1'b0, note_tmp_q};
            gate_d = 1'b1;
            vel_d  = rx_byte[6:0];
          end else if ({1'b0, note_tmp_q} == note_q) begin
            note_d = 8'd0;
            gate_d = 1'b0;
          end
        end
        default: begin
          note_tmp_d = note_tmp_q;
        end
      endcase
    end
    strobe_d = (note_d != note_q);
  end

  assign o_note_select = note_q;
  assign o_gate        = gate_q;
  assign o_velocity    = vel_q;
  assign o_note_strobe = strobe_q;
  assign o_frame_err   = frame_err_q;

endmodule
